// File: rtl/dt1_idex_stage_if.sv
// Decode-to-ID/EX handshake bundle: decoded instruction fields plus valid/ready.
interface dt1_idex_stage_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             id_valid;
  logic             id_ready;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_imm;
  logic [WIDTH-1:0] id_rs1_data;
  logic [WIDTH-1:0] id_rs2_data;
  logic [REGW-1:0]  id_rs1;
  logic [REGW-1:0]  id_rs2;
  logic [REGW-1:0]  id_rd;
  logic [3:0]       id_alu_ctrl;
  logic [1:0]       id_src_a;
  logic             id_src_b;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memwrite;
  logic             id_branch;
  logic             id_jump;

  modport master (
    output id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1, id_rs2, id_rd, id_alu_ctrl, id_src_a, id_src_b,
           id_regwrite, id_memread, id_memwrite, id_branch, id_jump,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1, id_rs2, id_rd, id_alu_ctrl, id_src_a, id_src_b,
           id_regwrite, id_memread, id_memwrite, id_branch, id_jump,
    output id_ready
  );
endinterface

// File: rtl/dt1_idex_stage.sv
// ID/EX pipeline register: operand forwarding from MEM/WB, ALU operand select,
// load-use bubble insertion, downstream backpressure and branch flush.
module dt1_idex_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  dt1_idex_stage_if.slave  id,
  input  logic             flush,
  input  logic             ex_ready,
  input  logic             mem_regwrite,
  input  logic [REGW-1:0]  mem_rd,
  input  logic [WIDTH-1:0] mem_result,
  input  logic             wb_regwrite,
  input  logic [REGW-1:0]  wb_rd,
  input  logic [WIDTH-1:0] wb_result,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_ctrl,
  output logic [WIDTH-1:0] ex_alu_a,
  output logic [WIDTH-1:0] ex_alu_b,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_imm,
  output logic [REGW-1:0]  ex_rd,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_branch,
  output logic             ex_jump
);

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'b00,
    SRC_A_PC   = 2'b01,
    SRC_A_ZERO = 2'b10,
    SRC_A_RSVD = 2'b11
  } src_a_e;

  logic [WIDTH-1:0] rs1_data_q;
  logic [WIDTH-1:0] rs2_data_q;
  logic [REGW-1:0]  rs1_q;
  logic [REGW-1:0]  rs2_q;
  src_a_e           src_a_q;
  logic             src_b_q;
  logic             regwrite_q;
  logic             memread_q;
  logic             memwrite_q;
  logic             branch_q;
  logic             jump_q;

  logic             adv;
  logic             hazard;
  logic             load;
  logic [WIDTH-1:0] fwd_rs1;
  logic [WIDTH-1:0] fwd_rs2;

  // Conservative load-use check: any rs index match stalls, used or not.
  assign adv    = !ex_valid || ex_ready;
  assign hazard = id.id_valid && ex_valid && memread_q && (ex_rd != '0) &&
                  ((ex_rd == id.id_rs1) || (ex_rd == id.id_rs2));
  assign id.id_ready = adv && !hazard && !flush;
  assign load        = id.id_valid && id.id_ready;

  // MEM overrides WB, WB overrides the stored register-file value.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (wb_regwrite && (wb_rd == rs1_q) && (rs1_q != '0))
      fwd_rs1 = wb_result;
    if (mem_regwrite && (mem_rd == rs1_q) && (rs1_q != '0))
      fwd_rs1 = mem_result;
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (wb_regwrite && (wb_rd == rs2_q) && (rs2_q != '0))
      fwd_rs2 = wb_result;
    if (mem_regwrite && (mem_rd == rs2_q) && (rs2_q != '0))
      fwd_rs2 = mem_result;
  end

  always_comb begin
    ex_alu_a = '0;
    case (src_a_q)
      SRC_A_RS1:  ex_alu_a = fwd_rs1;
      SRC_A_PC:   ex_alu_a = ex_pc;
      SRC_A_ZERO: ex_alu_a = '0;
      SRC_A_RSVD: ex_alu_a = '0;
      default:    ex_alu_a = '0;
    endcase
  end

  assign ex_alu_b      = src_b_q ? ex_imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;

  assign ex_regwrite = ex_valid && regwrite_q;
  assign ex_memread  = ex_valid && memread_q;
  assign ex_memwrite = ex_valid && memwrite_q;
  assign ex_branch   = ex_valid && branch_q;
  assign ex_jump     = ex_valid && jump_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_alu_ctrl <= '0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      src_a_q     <= SRC_A_RS1;
      src_b_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv) begin
      ex_valid <= id.id_valid && !hazard;
      if (load) begin
        ex_alu_ctrl <= id.id_alu_ctrl;
        ex_pc       <= id.id_pc;
        ex_imm      <= id.id_imm;
        ex_rd       <= id.id_rd;
        rs1_data_q  <= id.id_rs1_data;
        rs2_data_q  <= id.id_rs2_data;
        rs1_q       <= id.id_rs1;
        rs2_q       <= id.id_rs2;
        src_a_q     <= src_a_e'(id.id_src_a);
        src_b_q     <= id.id_src_b;
        regwrite_q  <= id.id_regwrite;
        memread_q   <= id.id_memread;
        memwrite_q  <= id.id_memwrite;
        branch_q    <= id.id_branch;
        jump_q      <= id.id_jump;
      end
    end else begin
      // Stalled: capture forwarded operands so a WB result leaving the pipe is kept.
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end
  end

endmodule

// File: tb/tb_dt1_idex_stage.sv
// Directed bench for dt1_idex_stage: scoreboard of expected EX outputs plus
// immediate-assertion checks of handshake, hazard, stall, flush and reset behaviour.
module tb_dt1_idex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        ex_ready;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        ex_valid;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_alu_a;
  logic [31:0] ex_alu_b;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_branch;
  logic        ex_jump;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [3:0]  fl;  // {regwrite, memread, memwrite, branch}
  } exp_t;

  exp_t sbq[$];

  dt1_idex_stage_if #(.WIDTH(32), .REGW(5)) idb ();

  dt1_idex_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .id            (idb),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .mem_regwrite  (mem_regwrite),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_regwrite   (wb_regwrite),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .ex_valid      (ex_valid),
    .ex_alu_ctrl   (ex_alu_ctrl),
    .ex_alu_a      (ex_alu_a),
    .ex_alu_b      (ex_alu_b),
    .ex_store_data (ex_store_data),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_rd         (ex_rd),
    .ex_regwrite   (ex_regwrite),
    .ex_memread    (ex_memread),
    .ex_memwrite   (ex_memwrite),
    .ex_branch     (ex_branch),
    .ex_jump       (ex_jump)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                      input logic [3:0] ctrl, input logic [4:0] rd, input logic [3:0] fl);
    exp_t e;
    e.a = a; e.b = b; e.st = st; e.ctrl = ctrl; e.rd = rd; e.fl = fl;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (ex_valid && ex_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_output", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("sb_alu_a",     ex_alu_a,      e.a);
        chk("sb_alu_b",     ex_alu_b,      e.b);
        chk("sb_store",     ex_store_data, e.st);
        chk("sb_ctrl",      32'(ex_alu_ctrl), 32'(e.ctrl));
        chk("sb_rd",        32'(ex_rd),    32'(e.rd));
        chk("sb_regwrite",  32'(ex_regwrite), 32'(e.fl[3]));
        chk("sb_memread",   32'(ex_memread),  32'(e.fl[2]));
        chk("sb_memwrite",  32'(ex_memwrite), 32'(e.fl[1]));
        chk("sb_branch",    32'(ex_branch),   32'(e.fl[0]));
        chk("sb_jump",      32'(ex_jump),     32'd0);
      end
    end
  endtask

  task automatic settle();
    #2;
    sb_check();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] rs1d, input logic [31:0] rs2d,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [1:0] sa,
                       input logic sb, input logic [3:0] fl);
    idb.id_valid    = 1'b1;
    idb.id_alu_ctrl = ctrl;
    idb.id_rs1      = rs1;
    idb.id_rs2      = rs2;
    idb.id_rd       = rd;
    idb.id_rs1_data = rs1d;
    idb.id_rs2_data = rs2d;
    idb.id_imm      = imm;
    idb.id_pc       = pc;
    idb.id_src_a    = sa;
    idb.id_src_b    = sb;
    idb.id_regwrite = fl[3];
    idb.id_memread  = fl[2];
    idb.id_memwrite = fl[1];
    idb.id_branch   = fl[0];
    idb.id_jump     = 1'b0;
  endtask

  task automatic idle();
    idb.id_valid = 1'b0;
  endtask

  task automatic set_fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                         input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    mem_regwrite = mw; mem_rd = mrd; mem_result = mres;
    wb_regwrite  = ww; wb_rd  = wrd; wb_result  = wres;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 4'b0000);
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    settle();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu_a", ex_alu_a, 32'd0);
    chk("rst_alu_b", ex_alu_b, 32'd0);
    chk("rst_ctrl",  32'(ex_alu_ctrl), 32'd0);
    chk("rst_regwrite", 32'(ex_regwrite), 32'd0);
    chk("rst_id_ready", 32'(idb.id_ready), 32'd1);
    clk_edge();

    // addi x1,x0,5
    drive(4'd0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd5, 32'h40, 2'd0, 1'b1, 4'b1000);
    push(32'd0, 32'd5, 32'd0, 4'd0, 5'd1, 4'b1000);
    settle();
    chk("addi_id_ready", 32'(idb.id_ready), 32'd1);
    clk_edge();

    // Forwarding priority, back to back
    drive(4'd0, 5'd3, 5'd0, 5'd7, 32'h11, 32'd0, 32'd0, 32'd0, 2'd0, 1'b1, 4'b1000);
    push(32'hAA, 32'd0, 32'd0, 4'd0, 5'd7, 4'b1000);
    settle();
    chk("addi_valid", 32'(ex_valid), 32'd1);
    clk_edge();

    set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    drive(4'd0, 5'd3, 5'd0, 5'd7, 32'h11, 32'd0, 32'd0, 32'd0, 2'd0, 1'b1, 4'b1000);
    push(32'hBB, 32'd0, 32'd0, 4'd0, 5'd7, 4'b1000);
    settle();
    clk_edge();

    set_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    drive(4'd0, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b1, 4'b1000);
    push(32'd0, 32'd0, 32'd0, 4'd0, 5'd7, 4'b1000);
    settle();
    clk_edge();

    set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    drive(4'd0, 5'd4, 5'd0, 5'd7, 32'h44, 32'd0, 32'd0, 32'd0, 2'd0, 1'b1, 4'b1000);
    push(32'h44, 32'd0, 32'd0, 4'd0, 5'd7, 4'b1000);
    settle();
    clk_edge();

    set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    drive(4'd0, 5'd3, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 32'h100, 2'd1, 1'b1, 4'b1000);
    push(32'h100, 32'd0, 32'd0, 4'd0, 5'd7, 4'b1000);
    settle();
    clk_edge();

    drive(4'd0, 5'd3, 5'd0, 5'd7, 32'h55, 32'd0, 32'd9, 32'd0, 2'd3, 1'b1, 4'b1000);
    push(32'd0, 32'd9, 32'd0, 4'd0, 5'd7, 4'b1000);
    settle();
    clk_edge();

    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle();
    settle();
    clk_edge();

    // Load-use: lw x5 then add x6,x5,x1
    drive(4'd0, 5'd2, 5'd0, 5'd5, 32'h1000, 32'd0, 32'd8, 32'd0, 2'd0, 1'b1, 4'b1100);
    push(32'h1000, 32'd8, 32'd0, 4'd0, 5'd5, 4'b1100);
    settle();
    chk("lw_id_ready", 32'(idb.id_ready), 32'd1);
    clk_edge();

    drive(4'd0, 5'd5, 5'd1, 5'd6, 32'd0, 32'd7, 32'd0, 32'd0, 2'd0, 1'b0, 4'b1000);
    settle();
    chk("loaduse_stall", 32'(idb.id_ready), 32'd0);
    clk_edge();

    push(32'hCAFE, 32'd7, 32'd7, 4'd0, 5'd6, 4'b1000);
    settle();
    chk("bubble_valid", 32'(ex_valid), 32'd0);
    chk("bubble_regwrite", 32'(ex_regwrite), 32'd0);
    chk("bubble_id_ready", 32'(idb.id_ready), 32'd1);
    clk_edge();

    idle();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hCAFE);
    settle();
    clk_edge();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // lw to x0 never stalls
    drive(4'd0, 5'd2, 5'd0, 5'd0, 32'h20, 32'd0, 32'd0, 32'd0, 2'd0, 1'b1, 4'b1100);
    push(32'h20, 32'd0, 32'd0, 4'd0, 5'd0, 4'b1100);
    settle();
    clk_edge();

    drive(4'd0, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 4'b1000);
    push(32'd0, 32'd0, 32'd0, 4'd0, 5'd12, 4'b1000);
    settle();
    chk("x0_nohazard", 32'(idb.id_ready), 32'd1);
    clk_edge();

    idle();
    settle();
    clk_edge();

    // Load-use on rs2 only, store data forwarded from WB
    drive(4'd0, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd4, 32'd0, 2'd0, 1'b1, 4'b1100);
    push(32'd0, 32'd4, 32'd0, 4'd0, 5'd9, 4'b1100);
    settle();
    clk_edge();

    drive(4'd0, 5'd0, 5'd9, 5'd0, 32'd0, 32'd0, 32'h10, 32'd0, 2'd0, 1'b1, 4'b0010);
    settle();
    chk("rs2_hazard", 32'(idb.id_ready), 32'd0);
    clk_edge();

    push(32'd0, 32'h10, 32'h99, 4'd0, 5'd0, 4'b0010);
    settle();
    clk_edge();

    idle();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    settle();
    clk_edge();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Backpressure while WB writes rs2
    drive(4'd1, 5'd8, 5'd9, 5'd10, 32'h10, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 4'b1000);
    push(32'h10, 32'h1234, 32'h1234, 4'd1, 5'd10, 4'b1000);
    settle();
    clk_edge();

    ex_ready = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234);
    drive(4'd0, 5'd0, 5'd0, 5'd11, 32'd0, 32'd0, 32'd3, 32'd0, 2'd0, 1'b1, 4'b1000);
    settle();
    chk("bp_id_ready", 32'(idb.id_ready), 32'd0);
    chk("bp_fwd_b", ex_alu_b, 32'h1234);
    chk("bp_valid", 32'(ex_valid), 32'd1);
    clk_edge();

    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle();
    chk("bp_hold_b", ex_alu_b, 32'h1234);
    chk("bp_hold_a", ex_alu_a, 32'h10);
    chk("bp_hold_ready", 32'(idb.id_ready), 32'd0);
    clk_edge();

    settle();
    chk("bp_hold_b2", ex_alu_b, 32'h1234);
    chk("bp_hold_store", ex_store_data, 32'h1234);
    clk_edge();

    ex_ready = 1'b1;
    push(32'd0, 32'd3, 32'd0, 4'd0, 5'd11, 4'b1000);
    settle();
    chk("bp_release_ready", 32'(idb.id_ready), 32'd1);
    clk_edge();

    idle();
    settle();
    clk_edge();

    // Flush: branch in EX, fetched instruction discarded
    drive(4'hC, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 4'b0001);
    push(32'd0, 32'd0, 32'd0, 4'hC, 5'd0, 4'b0001);
    settle();
    clk_edge();

    flush = 1'b1;
    drive(4'd0, 5'd0, 5'd0, 5'd13, 32'd0, 32'd0, 32'd1, 32'd0, 2'd0, 1'b1, 4'b1010);
    settle();
    chk("flush_id_ready", 32'(idb.id_ready), 32'd0);
    clk_edge();

    flush = 1'b0;
    drive(4'd0, 5'd0, 5'd0, 5'd14, 32'd0, 32'd0, 32'd2, 32'd0, 2'd0, 1'b1, 4'b1000);
    settle();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_regwrite", 32'(ex_regwrite), 32'd0);
    chk("flush_memwrite", 32'(ex_memwrite), 32'd0);
    chk("flush_next_ready", 32'(idb.id_ready), 32'd1);
    push(32'd0, 32'd2, 32'd0, 4'd0, 5'd14, 4'b1000);
    clk_edge();

    idle();
    settle();
    clk_edge();

    // Asynchronous reset during a stall
    drive(4'd2, 5'd6, 5'd0, 5'd15, 32'h77, 32'd0, 32'h99, 32'd0, 2'd0, 1'b1, 4'b1000);
    settle();
    clk_edge();

    idle();
    ex_ready = 1'b0;
    settle();
    chk("pre_reset_a", ex_alu_a, 32'h77);
    chk("pre_reset_b", ex_alu_b, 32'h99);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(ex_valid), 32'd0);
    chk("midrst_alu_a", ex_alu_a, 32'd0);
    chk("midrst_alu_b", ex_alu_b, 32'd0);
    chk("midrst_ctrl", 32'(ex_alu_ctrl), 32'd0);
    clk_edge();

    reset = 1'b0;
    ex_ready = 1'b1;
    settle();
    chk("postrst_valid", 32'(ex_valid), 32'd0);
    clk_edge();

    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
